burst_lock_controller: RTL and testbench

Sequences the chroma subcarrier PLL once per video line. It gates error accumulation to the colour-burst window and averages a fixed number of burst samples. It then runs a saturating PI update, publishes the NCO frequency offset, and tracks lock/unlock hysteresis and missing bursts. It sits between the sync separator/demodulator (burst flag, V-channel phase error) and the NCO phase-increment adder.

---
 rtl/color_pkg.sv | 21 ++
 rtl/burst_lock_controller_if.sv | 23 ++
 rtl/burst_lock_controller_pi_step.sv | 22 ++
 rtl/burst_lock_controller.sv | 159 +++++++++++++++
 tb/tb_burst_lock_controller.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/color_pkg.sv
// color_pkg: shared widths, FSM state type and saturating add for the burst lock controller
// Contents: OFFSET_W/ERR_W/WIDE_W widths, burst_lock_state_t, sat_add()
package color_pkg;
    localparam int OFFSET_W = 32;
    localparam int ERR_W = 12;
    localparam int WIDE_W = 34;

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, WAIT_END} burst_lock_state_t;

    // a + b clamped to [-lim, +lim], returned at offset width
    function automatic logic signed [OFFSET_W-1:0] sat_add(
        input logic signed [WIDE_W-1:0] a,
        input logic signed [WIDE_W-1:0] b,
        input logic signed [WIDE_W-1:0] lim
    );
        logic signed [WIDE_W-1:0] s;
        s = a + b;
        s = (s > lim) ? lim : (s < -lim) ? -lim : s;
        return s[OFFSET_W-1:0];
    endfunction
endpackage

// File: rtl/burst_lock_controller_if.sv
// burst_lock_controller_if: burst/error inputs and NCO/lock outputs of the burst lock controller
// Ports: burst_active, error_in, freeze (to controller); offset_out, offset_valid, avg_error,
// locked, color_kill (from controller). master = driver side, slave = controller side.
interface burst_lock_controller_if;
    import color_pkg::*;
    logic                       burst_active;
    logic signed [ERR_W-1:0]    error_in;
    logic                       freeze;
    logic signed [OFFSET_W-1:0] offset_out;
    logic                       offset_valid;
    logic signed [ERR_W-1:0]    avg_error;
    logic                       locked;
    logic                       color_kill;

    modport master (
        output burst_active, error_in, freeze,
        input  offset_out, offset_valid, avg_error, locked, color_kill
    );
    modport slave (
        input  burst_active, error_in, freeze,
        output offset_out, offset_valid, avg_error, locked, color_kill
    );
endinterface

// File: rtl/burst_lock_controller_pi_step.sv
// burst_pi_step: combinational saturating PI update of the chroma PLL
// Ports: avg (burst average), integ (current integrator) in; integ_next, offset out
module burst_pi_step
    import color_pkg::*;
#(
    parameter int KP_SHIFT     = 8,
    parameter int KI_SHIFT     = 2,
    parameter int OFFSET_LIMIT = 1048576
) (
    input  logic signed [ERR_W-1:0]    avg,
    input  logic signed [OFFSET_W-1:0] integ,
    output logic signed [OFFSET_W-1:0] integ_next,
    output logic signed [OFFSET_W-1:0] offset
);
    localparam logic signed [WIDE_W-1:0] LIM = WIDE_W'(OFFSET_LIMIT);

    logic signed [WIDE_W-1:0] avg_w;

    assign avg_w      = WIDE_W'(avg);
    assign integ_next = sat_add(WIDE_W'(integ), avg_w <<< KI_SHIFT, LIM);
    assign offset     = sat_add(WIDE_W'(integ_next), avg_w <<< KP_SHIFT, LIM);
endmodule

// File: rtl/burst_lock_controller.sv
// burst_lock_controller: per-line colour-burst averaging, PI update and lock tracking for the chroma PLL
// Ports: clk, rst (async, active-high), bus (slave): burst_active/error_in/freeze in;
// offset_out/offset_valid/avg_error/locked/color_kill out.
// Optional: BURST_LOCK_COLOR_KILL_EN builds a registered color_kill = ~locked (else tied 0).
module burst_lock_controller
    import color_pkg::*;
#(
    parameter int BURST_LOG2   = 4,
    parameter int KP_SHIFT     = 8,
    parameter int KI_SHIFT     = 2,
    parameter int OFFSET_LIMIT = 1048576,
    parameter int LOCK_THRESH  = 64,
    parameter int LOCK_LINES   = 8,
    parameter int UNLOCK_LINES = 4,
    parameter int LINE_TIMEOUT = 5000
) (
    input logic                    clk,
    input logic                    rst,
    burst_lock_controller_if.slave bus
);
    localparam int N      = 1 << BURST_LOG2;
    localparam int SUM_W  = ERR_W + BURST_LOG2;
    localparam int CNT_W  = BURST_LOG2 + 1;
    localparam int TMR_W  = $clog2(LINE_TIMEOUT + 1);
    localparam int GOOD_W = $clog2(LOCK_LINES + 1);
    localparam int BAD_W  = $clog2(UNLOCK_LINES + 1);

    burst_lock_state_t state, state_n;
    logic [TMR_W-1:0]           timer, timer_n;
    logic [CNT_W-1:0]           count, count_n;
    logic signed [SUM_W-1:0]    sum, sum_n, sample;
    logic signed [ERR_W-1:0]    avg, avg_q;
    logic [ERR_W:0]             avg_mag;
    logic signed [OFFSET_W-1:0] integ, integ_pi, offset_pi, offset_q;
    logic [GOOD_W-1:0]          good, good_n;
    logic [BAD_W-1:0]           bad, bad_n;
    logic                       miss, line_done, good_line;
    logic                       locked_q, locked_n, valid_q;

    assign sample    = SUM_W'(bus.error_in);
    assign avg       = ERR_W'(sum >>> BURST_LOG2);
    assign avg_mag   = avg[ERR_W-1] ? -(ERR_W+1)'(avg) : (ERR_W+1)'(avg);
    assign good_line = avg_mag <= (ERR_W+1)'(LOCK_THRESH);

    burst_pi_step #(
        .KP_SHIFT    (KP_SHIFT),
        .KI_SHIFT    (KI_SHIFT),
        .OFFSET_LIMIT(OFFSET_LIMIT)
    ) u_pi (
        .avg       (avg),
        .integ     (integ),
        .integ_next(integ_pi),
        .offset    (offset_pi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // a rising burst takes priority over a timer expiry in the same cycle
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        count_n   = count;
        sum_n     = sum;
        miss      = 1'b0;
        line_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.burst_active) begin
                    sum_n   = sample;
                    count_n = CNT_W'(1);
                    timer_n = '0;
                    state_n = (N == 1) ? UPDATE : ACCUM;
                end else if (timer == TMR_W'(LINE_TIMEOUT - 1)) begin
                    miss    = 1'b1;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ACCUM: begin
                if (bus.burst_active) begin
                    sum_n   = sum + sample;
                    count_n = count + 1'b1;
                    state_n = (count_n == CNT_W'(N)) ? UPDATE : ACCUM;
                end else begin
                    miss    = 1'b1;
                    state_n = IDLE;
                end
            end
            UPDATE: begin
                line_done = 1'b1;
                state_n   = WAIT_END;
            end
            default: state_n = bus.burst_active ? WAIT_END : IDLE;
        endcase
    end

    always_comb begin
        good_n   = good;
        bad_n    = bad;
        locked_n = locked_q;
        if (line_done && good_line) begin
            good_n = (good == GOOD_W'(LOCK_LINES)) ? good : good + 1'b1;
            bad_n  = '0;
        end else if (line_done || miss) begin
            bad_n  = (bad == BAD_W'(UNLOCK_LINES)) ? bad : bad + 1'b1;
            good_n = '0;
        end
        if (good_n == GOOD_W'(LOCK_LINES))  locked_n = 1'b1;
        if (bad_n == BAD_W'(UNLOCK_LINES)) locked_n = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer    <= '0;
            count    <= '0;
            sum      <= '0;
            integ    <= '0;
            good     <= '0;
            bad      <= '0;
            offset_q <= '0;
            valid_q  <= 1'b0;
            avg_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            timer    <= timer_n;
            count    <= count_n;
            sum      <= sum_n;
            good     <= good_n;
            bad      <= bad_n;
            locked_q <= locked_n;
            valid_q  <= line_done && !bus.freeze;
            if (line_done) avg_q <= avg;
            if (line_done && !bus.freeze) begin
                integ    <= integ_pi;
                offset_q <= offset_pi;
            end
        end
    end

    assign bus.offset_out   = offset_q;
    assign bus.offset_valid = valid_q;
    assign bus.avg_error    = avg_q;
    assign bus.locked       = locked_q;

`ifdef BURST_LOCK_COLOR_KILL_EN
    logic kill_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) kill_q <= 1'b1;
        else     kill_q <= ~locked_n;
    end
    assign bus.color_kill = kill_q;
`else
    assign bus.color_kill = 1'b0;
`endif
endmodule

// File: tb/tb_burst_lock_controller.sv
// tb_burst_lock_controller: directed scoreboard bench for burst_lock_controller
module tb_burst_lock_controller;
    localparam longint LIM = 1048576;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_end = 0;
    longint integ_m = 0;
    longint off_m = 0;
    int   good_m = 0;
    int   bad_m = 0;
    bit   lock_m = 0;
    logic signed [31:0] hold_off;
    logic signed [11:0] hold_avg;

    typedef struct {
        int     ecyc;
        longint off;
        int     avg;
        bit     lk;
    } exp_t;
    exp_t q[$];

    burst_lock_controller_if bus();

    burst_lock_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit kill_exp(input bit lk);
`ifdef BURST_LOCK_COLOR_KILL_EN
        return ~lk;
`else
        return 1'b0;
`endif
    endfunction

    function automatic longint sat(input longint x);
        return (x > LIM) ? LIM : (x < -LIM) ? -LIM : x;
    endfunction

    task automatic line_model(input int avg, input bit is_miss, input bit frz, input int ecyc);
        exp_t e;
        if (!is_miss && avg <= 64 && avg >= -64) begin
            good_m = (good_m == 8) ? 8 : good_m + 1;
            bad_m  = 0;
        end else begin
            bad_m  = (bad_m == 4) ? 4 : bad_m + 1;
            good_m = 0;
        end
        if (good_m == 8) lock_m = 1'b1;
        if (bad_m == 4)  lock_m = 1'b0;
        if (!is_miss && !frz) begin
            integ_m = sat(integ_m + avg * 4);
            off_m   = sat(integ_m + avg * 256);
            e.ecyc  = ecyc;
            e.off   = off_m;
            e.avg   = avg;
            e.lk    = lock_m;
            q.push_back(e);
        end
    endtask

    task automatic burst(input int v, input int len, input bit frz, input bit rel);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (rel && i == 0) rst = 1'b0;
            bus.burst_active = 1'b1;
            bus.error_in     = 12'(v);
            bus.freeze       = frz;
            if (i == 15) line_model(v, 1'b0, frz, cyc + 2);
        end
        if (len < 16) line_model(v, 1'b1, frz, 0);
        @(posedge clk); #1;
        bus.burst_active = 1'b0;
        last_end = cyc;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.offset_valid === 1'b1) begin
            if (q.size() == 0) chk("spurious_valid", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("valid_cycle", cyc, e.ecyc);
                chk("offset", bus.offset_out, e.off);
                chk("avg", bus.avg_error, e.avg);
                chk("locked", bus.locked, e.lk);
                chk("color_kill", bus.color_kill, kill_exp(e.lk));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.burst_active = 1'b0;
        bus.error_in = '0;
        bus.freeze = 1'b0;
        gap(2);
        chk("rst_offset", bus.offset_out, 0);
        chk("rst_valid", bus.offset_valid, 0);
        chk("rst_avg", bus.avg_error, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_kill", bus.color_kill, kill_exp(1'b0));
        rst = 1'b0;
        gap(3);

        burst(100, 20, 1'b0, 1'b0);
        gap(4);
        chk("first_offset", bus.offset_out, 26000);
        chk("first_avg", bus.avg_error, 100);
        burst(100, 20, 1'b0, 1'b0);
        gap(4);
        chk("second_offset", bus.offset_out, 26400);

        for (int i = 0; i < 7; i++) begin
            burst(10, 20, 1'b0, 1'b0);
            gap(3);
        end
        chk("lock_before_8th", bus.locked, 0);
        burst(10, 20, 1'b0, 1'b0);
        gap(3);
        chk("lock_after_8th", bus.locked, 1);
        chk("kill_after_8th", bus.color_kill, kill_exp(1'b1));

        burst(10, 20, 1'b0, 1'b0);
        hold_off = bus.offset_out;
        for (int i = 0; i < 25000 && bus.locked === 1'b1; i++) @(negedge clk);
        chk("unlock_locked", bus.locked, 0);
        chk("unlock_cycle", cyc, last_end + 20001);
        repeat (4) line_model(0, 1'b1, 1'b0, 0);
        gap(2);
        chk("unlock_offset_held", bus.offset_out, off_m);
        chk("unlock_kill", bus.color_kill, kill_exp(1'b0));

        hold_avg = bus.avg_error;
        burst(-20, 10, 1'b0, 1'b0);
        gap(4);
        chk("short_avg_held", bus.avg_error, hold_avg);
        burst(10, 16, 1'b0, 1'b0);
        gap(4);
        chk("after_short_avg", bus.avg_error, 10);

        for (int i = 0; i < 200; i++) begin
            burst(2047, 20, 1'b0, 1'b0);
            gap(2);
        end
        gap(2);
        chk("clamp_offset", bus.offset_out, 1048576);
        burst(-2047, 20, 1'b0, 1'b0);
        gap(4);
        chk("unclamp_offset", bus.offset_out, 516356);

        hold_off = bus.offset_out;
        burst(300, 20, 1'b1, 1'b0);
        gap(4);
        chk("freeze_offset", bus.offset_out, hold_off);
        chk("freeze_avg", bus.avg_error, 300);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus.burst_active = 1'b1;
            bus.error_in = 12'(50);
            bus.freeze = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_offset", bus.offset_out, 0);
        chk("mid_rst_avg", bus.avg_error, 0);
        chk("mid_rst_locked", bus.locked, 0);
        chk("mid_rst_valid", bus.offset_valid, 0);
        chk("mid_rst_kill", bus.color_kill, kill_exp(1'b0));
        integ_m = 0;
        off_m = 0;
        good_m = 0;
        bad_m = 0;
        lock_m = 1'b0;
        repeat (2) @(posedge clk);
        burst(50, 20, 1'b0, 1'b1);
        gap(4);
        chk("post_rst_offset", bus.offset_out, 13000);

        gap(10);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
